// File: rtl/weight_pack_pkg.sv
// Shared types and defaults for the weight row packer.
package weight_pack_pkg;

  // Job control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BW_DEF    = 4;
  localparam int COL_DEF   = 8;
  localparam int DEPTH_DEF = 4;

  // Row width is one symbol per column.
  function automatic int row_width(input int bw, input int col);
    return bw * col;
  endfunction

  localparam int ROW_W_DEF = row_width(BW_DEF, COL_DEF);

endpackage

// File: rtl/row_fifo.sv
// Synchronous row FIFO. A push while full is accepted only when a pop
// happens in the same cycle (the write lands in the slot being freed).
module row_fifo
  import weight_pack_pkg::*;
#(
  parameter int WIDTH = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_cnt == CNT_FULL);
  assign empty     = (r_cnt == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rp];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop_ok) r_rp <= r_rp + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/weight_row_packer.sv
// Packs BW-bit weight symbols into COL-wide rows and streams them to L0
// through a small row buffer. The input side cannot stall: rows completing
// into a full buffer with no concurrent pop are dropped and flagged.
// Optional macro WEIGHT_PACKER_FLUSH_EN adds a 'flush' input that closes
// the current partial row (zero-filled) and ends the job.
module weight_row_packer
  import weight_pack_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int COL   = COL_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef WEIGHT_PACKER_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 start,
  input  logic [15:0]          num_rows,
  input  logic [BW-1:0]        symbol_in,
  input  logic                 symbol_valid,
  input  logic                 l0_full,
  output logic                 l0_wr,
  output logic [BW*COL-1:0]    l0_din,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int ROW_W = row_width(BW, COL);
  localparam int KW    = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(COL - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [KW-1:0]    r_k;
  logic [ROW_W-1:0] r_asm;
  logic [15:0]      r_num_rows;
  logic [15:0]      r_rows;
  logic [15:0]      w_rows_inc;
  logic             r_ovf;
  logic             r_zero_done;

  logic             w_flush;
  logic             w_take;
  logic             w_row_done;
  logic             w_flush_row;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [ROW_W-1:0] w_asm_ins;
  logic [ROW_W-1:0] w_head;

`ifdef WEIGHT_PACKER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_take      = (r_state == RUN) && symbol_valid;
  assign w_row_done  = w_take && (r_k == K_LAST);
  // A flush closes a partial row only if it holds at least one symbol.
  assign w_flush_row = (r_state == RUN) && w_flush && !w_row_done &&
                       ((r_k != '0) || w_take);
  assign w_push      = w_row_done || w_flush_row;
  assign w_pop       = !w_empty && !l0_full;
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_rows_inc  = r_rows + 16'd1;

  assign l0_wr    = w_pop;
  assign l0_din   = w_head;
  assign overflow = r_ovf;

  // Assembly row with this cycle's symbol placed; unused lanes stay zero
  // because the register is cleared on every push.
  always_comb begin
    w_asm_ins = r_asm;
    if (w_take) w_asm_ins[int'(r_k)*BW +: BW] = symbol_in;
  end

  // Job state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = r_zero_done;
    case (r_state)
      IDLE: begin
        if (start && (num_rows != 16'd0)) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_flush || (w_push && (w_rows_inc == r_num_rows))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_empty) begin
          done        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lane index, assembly register, row count and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k         <= '0;
      r_asm       <= '0;
      r_num_rows  <= '0;
      r_rows      <= '0;
      r_ovf       <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_num_rows  <= num_rows;
        r_k         <= '0;
        r_asm       <= '0;
        r_rows      <= '0;
        r_ovf       <= 1'b0;
        r_zero_done <= (num_rows == 16'd0);
      end else if (r_state == RUN) begin
        if (w_push) begin
          r_asm  <= '0;
          r_k    <= '0;
          r_rows <= w_rows_inc;
          if (w_drop) r_ovf <= 1'b1;
        end else if (w_take) begin
          r_asm <= w_asm_ins;
          r_k   <= r_k + 1'b1;
        end
      end
    end
  end

  row_fifo #(.WIDTH(ROW_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_asm_ins),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_weight_row_packer.sv
// Self-checking bench for weight_row_packer (BW=4, COL=8, DEPTH=4).
module tb_weight_row_packer;

  localparam int COL   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        start;
  logic [15:0] num_rows;
  logic [3:0]  symbol_in;
  logic        symbol_valid;
  logic        l0_full;
  logic        l0_wr;
  logic [31:0] l0_din;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  weight_row_packer #(.BW(4), .COL(COL), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef WEIGHT_PACKER_FLUSH_EN
    .flush        (flush),
`endif
    .start        (start),
    .num_rows     (num_rows),
    .symbol_in    (symbol_in),
    .symbol_valid (symbol_valid),
    .l0_full      (l0_full),
    .l0_wr        (l0_wr),
    .l0_din       (l0_din),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: job phase, queued rows, collected symbols.
  int          m_st = 0;        // 0 idle, 1 collecting, 2 draining
  logic [31:0] m_q[$];
  logic [3:0]  m_syms[$];
  int          m_rows = 0;
  int          m_target = 0;
  bit          m_ovf = 0;
  bit          m_zd = 0;

  logic [31:0] wq[$];
  int          done_cnt;
  bit          busy_seen;
  logic [3:0]  hs[48];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  task automatic model_push_row();
    logic [31:0] row;
    row = '0;
    for (int i = 0; i < m_syms.size(); i++) row |= 32'(m_syms[i]) << (4*i);
    if (m_q.size() < DEPTH) m_q.push_back(row);
    else                    m_ovf = 1;
    m_syms.delete();
    m_rows++;
    if (m_rows == m_target) m_st = 2;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  // Entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit v, input logic [3:0] s, input bit full,
                     input bit st, input logic [15:0] n, input bit fl);
    bit e_wr;
    int pre;
    symbol_valid = v; symbol_in = s; l0_full = full;
    start = st; num_rows = n; flush = fl;
    #4;
    pre  = m_q.size();
    e_wr = (pre > 0) && !full;
    chk("l0_wr", {31'd0, l0_wr}, {31'd0, e_wr});
    if (e_wr) chk("l0_din", l0_din, m_q[0]);
    chk("busy", {31'd0, busy}, {31'd0, m_st != 0});
    chk("done", {31'd0, done}, {31'd0, (m_st == 2 && pre == 0) || m_zd});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (l0_wr === 1'b1) wq.push_back(l0_din);
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1;
    if (e_wr) void'(m_q.pop_front());
    m_zd = 0;
    case (m_st)
      0: if (st) begin
           if (n == 0) m_zd = 1;
           else begin
             m_st = 1; m_target = n; m_rows = 0; m_ovf = 0; m_syms.delete();
           end
         end
      1: begin
           if (v) begin
             m_syms.push_back(s);
             if (m_syms.size() == COL) model_push_row();
           end
`ifdef WEIGHT_PACKER_FLUSH_EN
           if (fl && m_st == 1) begin
             if (m_syms.size() > 0) model_push_row();
             m_st = 2;
           end
`endif
         end
      default: if (pre == 0) m_st = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      cyc(0, 4'h0, 0, 0, 16'd0, 0);
      i++;
    end
    chk("done_within_budget", {31'd0, done_cnt != d0}, 32'd1);
    cyc(0, 4'h0, 0, 0, 16'd0, 0);
    cyc(0, 4'h0, 0, 0, 16'd0, 0);
  endtask

  function automatic logic [31:0] pack_row(input int r);
    logic [31:0] row;
    row = '0;
    for (int i = 0; i < COL; i++) row |= 32'(hs[r*COL+i]) << (4*i);
    return row;
  endfunction

  typedef struct {
    int          nrows;
    int          nsym;
    logic [3:0]  sym0;
    int          step;
    int          exp_writes;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2,  16, 4'h1, 1, 2, 32'h87654321, 32'h0FEDCBA9, 0};
    vecs[1] = '{0,  0,  4'h0, 0, 0, 32'h0,        32'h0,        0};
    vecs[2] = '{1,  8,  4'hF, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
    vecs[3] = '{1,  8,  4'h0, 2, 1, 32'hECA86420, 32'hECA86420, 0};
    vecs[4] = '{3,  24, 4'h5, 3, 3, 32'hA741EB85, 32'hA741EB85, 0};

    reset_n = 0; flush = 0; start = 0; num_rows = 0;
    symbol_in = 0; symbol_valid = 0; l0_full = 0;
    #12;
    chk("rst_l0_wr", {31'd0, l0_wr}, 32'd0);
    chk("rst_l0_din", l0_din, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #3 reset_n = 1;
    @(posedge clk); #1;

    // Table-driven jobs.
    foreach (vecs[j]) begin
      wq.delete(); done_cnt = 0; busy_seen = 0;
      cyc(0, 4'h0, 0, 1, 16'(vecs[j].nrows), 0);
      for (int i = 0; i < vecs[j].nsym; i++)
        cyc(1, 4'(vecs[j].sym0 + i*vecs[j].step), 0, 0, 16'd0, 0);
      wait_done(40);
      chk($sformatf("vec%0d_writes", j), wq.size(), vecs[j].exp_writes);
      if (vecs[j].exp_writes > 0 && wq.size() > 0) begin
        chk($sformatf("vec%0d_first", j), wq[0], vecs[j].exp_first);
        chk($sformatf("vec%0d_last", j), wq[wq.size()-1], vecs[j].exp_last);
      end
      chk($sformatf("vec%0d_ovf", j), {31'd0, overflow}, {31'd0, vecs[j].exp_ovf});
      chk($sformatf("vec%0d_done_cnt", j), done_cnt, 1);
      chk($sformatf("vec%0d_busy_seen", j), {31'd0, busy_seen}, {31'd0, vecs[j].nrows != 0});
    end

    // L0 held full: four rows buffer, rows 5 and 6 drop.
    wq.delete(); done_cnt = 0;
    cyc(0, 4'h0, 1, 1, 16'd6, 0);
    for (int i = 0; i < 48; i++) begin
      hs[i] = 4'($urandom);
      cyc(1, hs[i], 1, 0, 16'd0, 0);
    end
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_no_write_while_full", wq.size(), 0);
    wait_done(40);
    chk("ovf_writes", wq.size(), 4);
    for (int r = 0; r < 4 && r < wq.size(); r++)
      chk($sformatf("ovf_row%0d", r), wq[r], pack_row(r));
    chk("ovf_done_cnt", done_cnt, 1);

    // Buffer full; a row completes in the very cycle L0 frees up.
    wq.delete(); done_cnt = 0;
    cyc(0, 4'h0, 1, 1, 16'd5, 0);
    for (int i = 0; i < 40; i++) cyc(1, 4'($urandom), i != 39, 0, 16'd0, 0);
    wait_done(40);
    chk("pushpop_writes", wq.size(), 5);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd0);

    // Reset mid-row with two rows buffered.
    wq.delete();
    cyc(0, 4'h0, 1, 1, 16'd4, 0);
    for (int i = 0; i < 21; i++) cyc(1, 4'($urandom), 1, 0, 16'd0, 0);
    l0_full = 0;
    #2 reset_n = 0;
    #1;
    chk("midrst_l0_wr", {31'd0, l0_wr}, 32'd0);
    chk("midrst_l0_din", l0_din, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    m_q.delete(); m_syms.delete(); m_st = 0; m_rows = 0; m_ovf = 0; m_zd = 0;
    @(posedge clk); #3 reset_n = 1;
    @(posedge clk); #1;
    wq.delete(); done_cnt = 0;
    cyc(0, 4'h0, 0, 1, 16'd1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 4'(i + 1), 0, 0, 16'd0, 0);
    wait_done(40);
    chk("postrst_writes", wq.size(), 1);
    if (wq.size() > 0) chk("postrst_row", wq[0], 32'h87654321);

    // Randomized jobs with random gaps, back-pressure and stray starts.
    for (int j = 0; j < 8; j++) begin
      int cnt;
      cyc(0, 4'h0, 0, 1, 16'($urandom_range(1, 5)), 0);
      cnt = 0;
      while (m_st == 1 && cnt < 400) begin
        cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0, 16'($urandom_range(0, 9)), 0);
        cnt++;
      end
      wait_done(60);
    end

`ifdef WEIGHT_PACKER_FLUSH_EN
    // Partial row closed by flush.
    wq.delete(); done_cnt = 0;
    cyc(0, 4'h0, 0, 1, 16'd4, 0);
    cyc(1, 4'hA, 0, 0, 16'd0, 0);
    cyc(1, 4'hB, 0, 0, 16'd0, 0);
    cyc(1, 4'hC, 0, 0, 16'd0, 0);
    cyc(0, 4'h0, 0, 0, 16'd0, 1);
    wait_done(20);
    chk("flush_writes", wq.size(), 1);
    if (wq.size() > 0) chk("flush_row", wq[0], 32'h00000CBA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
